// File: rtl/tlb_lookup_resp_pkg.sv
// Shared CPU TLB definitions: entry layout, default size, field widths and the
// VPN2/ASID match rule used by every TLB search port.
`timescale 1ns/1ps
package tlb_lookup_resp_pkg;

    localparam int unsigned TLBNUM_DEFAULT = 16;
    localparam int unsigned VPN2_W         = 19;
    localparam int unsigned ASID_W         = 8;
    localparam int unsigned PFN_W          = 20;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PFN_W-1:0]  pfn0;
        logic [2:0]        c0;
        logic              d0;
        logic              v0;
        logic [PFN_W-1:0]  pfn1;
        logic [2:0]        c1;
        logic              d1;
        logic              v1;
    } TLB_Entry;

    // Global entries ignore the ASID; the valid bits play no part in matching.
    function automatic logic entry_match(input TLB_Entry e,
                                         input logic [VPN2_W-1:0] vpn2,
                                         input logic [ASID_W-1:0] asid);
        return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
    endfunction

endpackage

// File: rtl/tlb_lookup_resp_match.sv
// tlb_match: combinational search of the entry array; the lowest matching
// index wins.
`timescale 1ns/1ps
module tlb_match
    import tlb_lookup_resp_pkg::*;
#(
    parameter int unsigned TLBNUM = TLBNUM_DEFAULT,
    parameter int unsigned IDX_W  = $clog2(TLBNUM)
) (
    input  logic [VPN2_W-1:0] vpn2,
    input  logic [ASID_W-1:0] asid,
    input  TLB_Entry          entries [TLBNUM],
    output logic              found,
    output logic [IDX_W-1:0]  index
);

    logic unused_fields;

    // Priority encoder: the first hit in ascending order is kept.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            if (!found && entry_match(entries[i], vpn2, asid)) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

    // Page-frame fields are carried through the array but not searched.
    always_comb begin
        unused_fields = 1'b0;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            unused_fields = unused_fields ^ (^entries[i]);
        end
    end

endmodule

// File: rtl/tlb_lookup_resp.sv
// tlb_lookup_resp: TLB entry store with registered lookup, probe and read
// ports, TLBWI/TLBWR writes and a change-notify pulse.
// Build option: define TLB_RANDOM_EN to enable the Random counter and make
// wr_random target entry[cp0_random]; otherwise wr_random acts like we.
`timescale 1ns/1ps
module tlb_lookup_resp
    import tlb_lookup_resp_pkg::*;
#(
    parameter int unsigned TLBNUM = TLBNUM_DEFAULT,
    parameter int unsigned IDX_W  = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s1_req,
    input  logic [VPN2_W-1:0] s1_vpn2,
    input  logic [ASID_W-1:0] s1_asid,
    output logic              s1_resp_valid,
    output logic              s1_found,
    output logic [IDX_W-1:0]  s1_index,
    output TLB_Entry          s1_entry,
    input  logic              we,
    input  logic              wr_random,
    input  logic [IDX_W-1:0]  w_index,
    input  TLB_Entry          w_entry,
    input  logic              r_req,
    input  logic [IDX_W-1:0]  r_index,
    output logic              r_valid,
    output TLB_Entry          r_entry,
    input  logic              p_req,
    input  logic [VPN2_W-1:0] p_vpn2,
    input  logic [ASID_W-1:0] p_asid,
    output logic              p_valid,
    output logic              p_found,
    output logic [IDX_W-1:0]  p_index,
    input  logic [IDX_W-1:0]  cp0_wired,
    output logic [IDX_W-1:0]  cp0_random,
    output logic              tlb_changed
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(TLBNUM - 1);

    TLB_Entry         entries [TLBNUM];
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             s1_hit;
    logic [IDX_W-1:0] s1_hit_idx;
    logic             p_hit;
    logic [IDX_W-1:0] p_hit_idx;

    assign wr_en = we | wr_random;

`ifdef TLB_RANDOM_EN
    logic [IDX_W-1:0] random_q;

    // Random counts down to Wired then wraps; an out-of-range Wired pins it high.
    always_ff @(posedge clk) begin
        if (rst) begin
            random_q <= LAST;
        end else if ((cp0_wired >= LAST) || (random_q <= cp0_wired)) begin
            random_q <= LAST;
        end else begin
            random_q <= random_q - IDX_W'(1);
        end
    end

    assign cp0_random = random_q;
    assign wr_idx     = we ? w_index : random_q;
`else
    logic unused_wired;

    assign cp0_random   = LAST;
    assign wr_idx       = w_index;
    assign unused_wired = ^cp0_wired;
`endif

    // Entry store; searches in the write cycle see the pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < TLBNUM; i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            entries[wr_idx] <= w_entry;
        end
    end

    tlb_match #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) u_lookup_match (
        .vpn2    (s1_vpn2),
        .asid    (s1_asid),
        .entries (entries),
        .found   (s1_hit),
        .index   (s1_hit_idx)
    );

    tlb_match #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) u_probe_match (
        .vpn2    (p_vpn2),
        .asid    (p_asid),
        .entries (entries),
        .found   (p_hit),
        .index   (p_hit_idx)
    );

    // Lookup response: captured on request, held until the next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_resp_valid <= 1'b0;
            s1_found      <= 1'b0;
            s1_index      <= '0;
            s1_entry      <= '0;
        end else begin
            s1_resp_valid <= s1_req;
            if (s1_req) begin
                s1_found <= s1_hit;
                s1_index <= s1_hit_idx;
                s1_entry <= s1_hit ? entries[s1_hit_idx] : '0;
            end
        end
    end

    // Probe result: captured on request, held until the next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_found <= 1'b0;
            p_index <= '0;
        end else begin
            p_valid <= p_req;
            if (p_req) begin
                p_found <= p_hit;
                p_index <= p_hit_idx;
            end
        end
    end

    // Indexed read (TLBR) and the one-cycle change notification.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_entry     <= '0;
            tlb_changed <= 1'b0;
        end else begin
            r_valid     <= r_req;
            tlb_changed <= wr_en;
            if (r_req) begin
                r_entry <= entries[r_index];
            end
        end
    end

endmodule

// File: tb/tb_tlb_lookup_resp.sv
// Self-checking bench for tlb_lookup_resp; honours TLB_RANDOM_EN when defined.
`timescale 1ns/1ps
module tb_tlb_lookup_resp;
    import tlb_lookup_resp_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned IW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              s1_req;
    logic [VPN2_W-1:0] s1_vpn2;
    logic [ASID_W-1:0] s1_asid;
    logic              s1_resp_valid;
    logic              s1_found;
    logic [IW-1:0]     s1_index;
    TLB_Entry          s1_entry;
    logic              we;
    logic              wr_random;
    logic [IW-1:0]     w_index;
    TLB_Entry          w_entry;
    logic              r_req;
    logic [IW-1:0]     r_index;
    logic              r_valid;
    TLB_Entry          r_entry;
    logic              p_req;
    logic [VPN2_W-1:0] p_vpn2;
    logic [ASID_W-1:0] p_asid;
    logic              p_valid;
    logic              p_found;
    logic [IW-1:0]     p_index;
    logic [IW-1:0]     cp0_wired;
    logic [IW-1:0]     cp0_random;
    logic              tlb_changed;

    tlb_lookup_resp #(.TLBNUM(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_asid(s1_asid),
        .s1_resp_valid(s1_resp_valid), .s1_found(s1_found),
        .s1_index(s1_index), .s1_entry(s1_entry),
        .we(we), .wr_random(wr_random), .w_index(w_index), .w_entry(w_entry),
        .r_req(r_req), .r_index(r_index), .r_valid(r_valid), .r_entry(r_entry),
        .p_req(p_req), .p_vpn2(p_vpn2), .p_asid(p_asid),
        .p_valid(p_valid), .p_found(p_found), .p_index(p_index),
        .cp0_wired(cp0_wired), .cp0_random(cp0_random), .tlb_changed(tlb_changed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          found;
        logic [IW-1:0] index;
        TLB_Entry      entry;
    } s1_exp_t;

    typedef struct {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              found;
        logic [IW-1:0]     index;
    } vec_t;

    s1_exp_t  s1_q[$];
    TLB_Entry shadow [N];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic TLB_Entry mk(input logic [VPN2_W-1:0] vpn2, input logic [ASID_W-1:0] asid,
                                    input logic g, input logic [PFN_W-1:0] pfn0, input logic v0);
        TLB_Entry e;
        e      = '0;
        e.vpn2 = vpn2;
        e.asid = asid;
        e.g    = g;
        e.pfn0 = pfn0;
        e.v0   = v0;
        e.pfn1 = pfn0 ^ 20'hFFFFF;
        e.v1   = 1'b1;
        return e;
    endfunction

    // Inputs change 1 ns after the falling edge, clear of the active edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_lookup(input logic [VPN2_W-1:0] vpn2, input logic [ASID_W-1:0] asid,
                               input logic found, input logic [IW-1:0] index);
        s1_exp_t x;
        s1_req  = 1'b1;
        s1_vpn2 = vpn2;
        s1_asid = asid;
        x.found = found;
        x.index = found ? index : '0;
        x.entry = found ? shadow[index] : '0;
        s1_q.push_back(x);
    endtask

    task automatic wr(input logic [IW-1:0] idx, input TLB_Entry e);
        we      = 1'b1;
        w_index = idx;
        w_entry = e;
        tick();
        shadow[idx] = e;
        we = 1'b0;
        chk("tlb_changed_after_we", tlb_changed, 1);
    endtask

    // Scoreboard: every response must match the oldest expectation, exactly one cycle later.
    always @(negedge clk) begin
        if (s1_resp_valid) begin
            if (s1_q.size() == 0) begin
                chk("s1_unexpected_resp", s1_resp_valid, 0);
            end else begin
                s1_exp_t x;
                x = s1_q.pop_front();
                chk("s1_found", s1_found, x.found);
                chk("s1_index", s1_index, x.index);
                chk("s1_entry", s1_entry, x.entry);
            end
        end else if (s1_q.size() != 0) begin
            void'(s1_q.pop_front());
            chk("s1_missing_resp", s1_resp_valid, 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t     vecs [8];
        TLB_Entry old3;
        TLB_Entry e9;
        logic     seen9;

        for (int i = 0; i < int'(N); i++) shadow[i] = '0;
        rst = 1'b1; s1_req = 1'b0; s1_vpn2 = '0; s1_asid = '0;
        we = 1'b0; wr_random = 1'b0; w_index = '0; w_entry = '0;
        r_req = 1'b0; r_index = '0; p_req = 1'b0; p_vpn2 = '0; p_asid = '0;
        cp0_wired = 4'd4;

        tick(); tick();
        chk("rst_s1_resp_valid", s1_resp_valid, 0);
        chk("rst_s1_found", s1_found, 0);
        chk("rst_s1_index", s1_index, 0);
        chk("rst_s1_entry", s1_entry, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_entry", r_entry, 0);
        chk("rst_p_valid", p_valid, 0);
        chk("rst_p_found", p_found, 0);
        chk("rst_p_index", p_index, 0);
        chk("rst_tlb_changed", tlb_changed, 0);
        chk("rst_cp0_random", cp0_random, 15);
        rst = 1'b0;

        e9 = mk(19'h00999, 8'd1, 1'b0, 20'h00909, 1'b1);
`ifdef TLB_RANDOM_EN
        begin
            logic [IW-1:0] exp_r;
            exp_r = 4'd15;
            for (int k = 0; k < 15; k++) begin
                tick();
                exp_r = (exp_r == 4'd4) ? 4'd15 : exp_r - 4'd1;
                chk("cp0_random_seq", cp0_random, exp_r);
            end
        end
        seen9 = 1'b0;
        for (int k = 0; k < 40 && !seen9; k++) begin
            tick();
            if (cp0_random == 4'd9) seen9 = 1'b1;
        end
        chk("cp0_random_reaches_9", seen9, 1);
        wr_random = 1'b1;
        w_index   = 4'd0;
        w_entry   = e9;
`else
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("cp0_random_const", cp0_random, 15);
        end
        seen9     = 1'b1;
        wr_random = 1'b1;
        w_index   = 4'd9;
        w_entry   = e9;
`endif
        tick();
        shadow[9] = e9;
        wr_random = 1'b0;
        chk("tlb_changed_after_wr_random", tlb_changed, seen9);

        wr(4'd3,  mk(19'h00400, 8'd5,    1'b0, 20'h00111, 1'b1));
        wr(4'd2,  mk(19'h01234, 8'h11,   1'b1, 20'h00222, 1'b1));
        wr(4'd7,  mk(19'h01234, 8'h77,   1'b1, 20'h00777, 1'b0));
        wr(4'd10, mk(19'h00055, 8'd9,    1'b0, 20'h00AAA, 1'b1));
        tick();
        chk("tlb_changed_pulse_end", tlb_changed, 0);

        vecs[0] = '{19'h00400, 8'd5,   1'b1, 4'd3};
        vecs[1] = '{19'h00400, 8'd6,   1'b0, 4'd0};
        vecs[2] = '{19'h01234, 8'h33,  1'b1, 4'd2};
        vecs[3] = '{19'h01234, 8'h77,  1'b1, 4'd2};
        vecs[4] = '{19'h00055, 8'd8,   1'b0, 4'd0};
        vecs[5] = '{19'h7FFFF, 8'hFF,  1'b0, 4'd0};
        vecs[6] = '{19'h00055, 8'd9,   1'b1, 4'd10};
        vecs[7] = '{19'h00999, 8'd1,   1'b1, 4'd9};
        for (int i = 0; i < 8; i++) begin
            push_lookup(vecs[i].vpn2, vecs[i].asid, vecs[i].found, vecs[i].index);
            tick();
        end
        s1_req = 1'b0;
        tick();
        chk("s1_idle_no_valid", s1_resp_valid, 0);
        chk("s1_found_held", s1_found, 1);
        chk("s1_index_held", s1_index, 9);

        // Write and lookup of the same VPN2 in one cycle.
        old3 = shadow[3];
        push_lookup(19'h00400, 8'd5, 1'b1, 4'd3);
        we      = 1'b1;
        w_index = 4'd3;
        w_entry = mk(19'h00400, 8'd5, 1'b0, 20'h00333, 1'b1);
        tick();
        shadow[3] = w_entry;
        s1_req = 1'b0;
        we     = 1'b0;
        chk("tlb_changed_same_cycle", tlb_changed, 1);
        wr(4'd3, mk(19'h00400, 8'd5, 1'b0, 20'h00444, 1'b1));
        chk("s1_entry_held_after_write", s1_entry, old3);
        push_lookup(19'h00400, 8'd5, 1'b1, 4'd3);
        tick();
        s1_req = 1'b0;

        // Lookup, read and probe together.
        push_lookup(19'h01234, 8'h99, 1'b1, 4'd2);
        r_req = 1'b1; r_index = 4'd3;
        p_req = 1'b1; p_vpn2 = 19'h00055; p_asid = 8'd9;
        tick();
        chk("r_valid", r_valid, 1);
        chk("r_entry_idx3", r_entry, shadow[3]);
        chk("p_valid", p_valid, 1);
        chk("p_found_hit", p_found, 1);
        chk("p_index_hit", p_index, 10);
        s1_req = 1'b0;
        r_index = 4'd9;
        p_vpn2 = 19'h00055; p_asid = 8'd8;
        tick();
        chk("r_entry_idx9", r_entry, shadow[9]);
        chk("p_found_miss", p_found, 0);
        chk("p_index_miss", p_index, 0);
        r_req = 1'b0;
        p_vpn2 = 19'h01234; p_asid = 8'd0;
        tick();
        chk("r_valid_idle", r_valid, 0);
        chk("p_index_lowest", p_index, 2);
        p_req = 1'b0;
        tick();
        chk("p_valid_idle", p_valid, 0);

        // Reset arriving with requests in flight.
        s1_req = 1'b1; s1_vpn2 = 19'h00400; s1_asid = 8'd5;
        r_req = 1'b1; p_req = 1'b1; we = 1'b1; w_index = 4'd5;
        rst = 1'b1;
        tick();
        for (int i = 0; i < int'(N); i++) shadow[i] = '0;
        chk("midrst_s1_resp_valid", s1_resp_valid, 0);
        chk("midrst_s1_entry", s1_entry, 0);
        chk("midrst_r_valid", r_valid, 0);
        chk("midrst_p_valid", p_valid, 0);
        chk("midrst_tlb_changed", tlb_changed, 0);
        rst = 1'b0; s1_req = 1'b0; r_req = 1'b0; p_req = 1'b0; we = 1'b0;
        tick();
        chk("postrst_no_resp", s1_resp_valid, 0);
        chk("postrst_no_changed", tlb_changed, 0);
        push_lookup(19'h00000, 8'd0, 1'b1, 4'd0);
        p_req = 1'b1; p_vpn2 = 19'h00400; p_asid = 8'd5;
        r_req = 1'b1; r_index = 4'd3;
        tick();
        s1_req = 1'b0; p_req = 1'b0; r_req = 1'b0;
        chk("postrst_v0_clear", s1_entry.v0, 0);
        chk("postrst_probe_miss", p_found, 0);
        chk("postrst_r_entry", r_entry, 0);
        tick();
        tick();
        chk("s1_queue_drained", s1_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
